// File: rtl/ay_pkg.sv
// Shared definitions for the AY-3-8910 compatible bus front end.
// Holds the bus-mode encodings, register index names and the per-register
// storage mask table.
package ay_pkg;

    // Bus mode encoding, {bdir, bc1}
    localparam logic [1:0] MODE_INACTIVE = 2'b00;
    localparam logic [1:0] MODE_READ     = 2'b01;
    localparam logic [1:0] MODE_WRITE    = 2'b10;
    localparam logic [1:0] MODE_LATCH    = 2'b11;

    // Register indices
    localparam logic [3:0] R_TONE_A_LO = 4'd0;
    localparam logic [3:0] R_TONE_A_HI = 4'd1;
    localparam logic [3:0] R_TONE_B_LO = 4'd2;
    localparam logic [3:0] R_TONE_B_HI = 4'd3;
    localparam logic [3:0] R_TONE_C_LO = 4'd4;
    localparam logic [3:0] R_TONE_C_HI = 4'd5;
    localparam logic [3:0] R_NOISE     = 4'd6;
    localparam logic [3:0] R_MIXER     = 4'd7;
    localparam logic [3:0] R_AMP_A     = 4'd8;
    localparam logic [3:0] R_AMP_B     = 4'd9;
    localparam logic [3:0] R_AMP_C     = 4'd10;
    localparam logic [3:0] R_ENV_LO    = 4'd11;
    localparam logic [3:0] R_ENV_HI    = 4'd12;
    localparam logic [3:0] R_ENV_SHAPE = 4'd13;
    localparam logic [3:0] R_IO_A      = 4'd14;
    localparam logic [3:0] R_IO_B      = 4'd15;

    // Storage mask per register, entry [15] leftmost. R7 drops bits 7:6
    // because they are IO-port direction controls that this block does not keep.
    localparam logic [15:0][7:0] REG_MASK = {
        8'hFF, 8'hFF, 8'h0F, 8'hFF,   // R15..R12
        8'hFF, 8'h1F, 8'h1F, 8'h1F,   // R11..R8
        8'h3F, 8'h1F, 8'h0F, 8'hFF,   // R7..R4
        8'h0F, 8'hFF, 8'h0F, 8'hFF    // R3..R0
    };

endpackage

// File: rtl/ay_bus_sync.sv
// Multi-stage synchroniser for the asynchronous AY bus pins.
// Control and data go through the same depth so the data stays aligned
// with the decoded bus mode.
//   clk, reset        : system clock, synchronous active-high reset
//   i_bdir/i_bc1      : raw bus control pins
//   i_data            : raw DA bus
//   o_bdir/o_bc1/o_data : synchronised copies, STAGES cycles later
module ay_bus_sync #(
    parameter int STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_bdir,
    input  logic       i_bc1,
    input  logic [7:0] i_data,
    output logic       o_bdir,
    output logic       o_bc1,
    output logic [7:0] o_data
);

    logic [9:0] r_stage [STAGES];

    // Shift chain; reset to all zeros so the decoded mode is INACTIVE
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= 10'd0;
            end
        end else begin
            r_stage[0] <= {i_bdir, i_bc1, i_data};
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_bdir = r_stage[STAGES-1][9];
    assign o_bc1  = r_stage[STAGES-1][8];
    assign o_data = r_stage[STAGES-1][7:0];

endmodule

// File: rtl/ay_bus_register_file.sv
// AY-3-8910 compatible CPU bus front end and 16-entry register file.
// Decodes the synchronised bus mode, commits address latches and register
// writes when a bus phase ends, serves reads, and pulses env_restart on
// every committed envelope-shape write.
//   clk, reset          : system clock, synchronous active-high reset
//   i_bdir/i_bc1/i_data_in : raw bus pins
//   o_data_out/o_data_oe   : registered read data and pad output enable
//   o_tone_period_a/b/c, o_noise_period, o_mixer, o_amp_a/b/c,
//   o_env_period, o_env_shape : register fields, straight from the flops
//   o_env_restart          : one-cycle pulse per committed R13 write
module ay_bus_register_file
    import ay_pkg::*;
#(
    parameter logic [3:0] CHIP_ADDR   = 4'h0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_bdir,
    input  logic        i_bc1,
    input  logic [7:0]  i_data_in,
    output logic [7:0]  o_data_out,
    output logic        o_data_oe,
    output logic [11:0] o_tone_period_a,
    output logic [11:0] o_tone_period_b,
    output logic [11:0] o_tone_period_c,
    output logic [4:0]  o_noise_period,
    output logic [5:0]  o_mixer,
    output logic [4:0]  o_amp_a,
    output logic [4:0]  o_amp_b,
    output logic [4:0]  o_amp_c,
    output logic [15:0] o_env_period,
    output logic [3:0]  o_env_shape,
    output logic        o_env_restart
);

    // FSM states share the bus-mode encoding so the next state is just m
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_READ  = 2'b01;
    localparam logic [1:0] ST_WRITE = 2'b10;
    localparam logic [1:0] ST_LATCH = 2'b11;

    logic             w_bdir;
    logic             w_bc1;
    logic [7:0]       w_data;
    logic [1:0]       w_mode;
    logic             w_latch_commit;
    logic             w_write_commit;
    logic [3:0]       w_addr;
    logic             w_selected;

    logic [1:0]       r_state;
    logic [7:0]       r_sample;
    logic [3:0]       r_addr;
    logic             r_selected;
    logic [15:0][7:0] r_regs;
    logic [7:0]       r_data_out;
    logic             r_data_oe;
    logic             r_env_restart;

    ay_bus_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .i_bdir (i_bdir),
        .i_bc1  (i_bc1),
        .i_data (i_data_in),
        .o_bdir (w_bdir),
        .o_bc1  (w_bc1),
        .o_data (w_data)
    );

    assign w_mode = {w_bdir, w_bc1};

    // A phase commits on the first cycle the synchronised mode differs from it
    assign w_latch_commit = (r_state == ST_LATCH) && (w_mode != MODE_LATCH);
    assign w_write_commit = (r_state == ST_WRITE) && (w_mode != MODE_WRITE) && r_selected;

    // Forward a committing latch so a phase entered directly after it
    // already sees the new address and chip select
    assign w_addr     = w_latch_commit ? r_sample[3:0] : r_addr;
    assign w_selected = w_latch_commit ? (r_sample[7:4] == CHIP_ADDR) : r_selected;

    // Bus FSM, address latch, register file and read port
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_sample      <= 8'h00;
            r_addr        <= 4'h0;
            r_selected    <= 1'b0;
            r_regs        <= '0;
            r_data_out    <= 8'h00;
            r_data_oe     <= 1'b0;
            r_env_restart <= 1'b0;
        end else begin
            r_state <= w_mode;

            if ((w_mode == MODE_LATCH) || (w_mode == MODE_WRITE)) begin
                r_sample <= w_data;
            end

            if (w_latch_commit) begin
                r_addr     <= r_sample[3:0];
                r_selected <= (r_sample[7:4] == CHIP_ADDR);
            end

            if (w_write_commit) begin
                r_regs[r_addr] <= r_sample & REG_MASK[r_addr];
            end

            r_env_restart <= w_write_commit && (r_addr == R_ENV_SHAPE);

            r_data_oe <= (w_mode == MODE_READ) && w_selected;

            if (w_mode == MODE_READ) begin
                r_data_out <= r_regs[w_addr] & REG_MASK[w_addr];
            end
        end
    end

    assign o_data_out      = r_data_out;
    assign o_data_oe       = r_data_oe;
    assign o_env_restart   = r_env_restart;

    assign o_tone_period_a = {r_regs[R_TONE_A_HI][3:0], r_regs[R_TONE_A_LO]};
    assign o_tone_period_b = {r_regs[R_TONE_B_HI][3:0], r_regs[R_TONE_B_LO]};
    assign o_tone_period_c = {r_regs[R_TONE_C_HI][3:0], r_regs[R_TONE_C_LO]};
    assign o_noise_period  = r_regs[R_NOISE][4:0];
    assign o_mixer         = r_regs[R_MIXER][5:0];
    assign o_amp_a         = r_regs[R_AMP_A][4:0];
    assign o_amp_b         = r_regs[R_AMP_B][4:0];
    assign o_amp_c         = r_regs[R_AMP_C][4:0];
    assign o_env_period    = {r_regs[R_ENV_HI], r_regs[R_ENV_LO]};
    assign o_env_shape     = r_regs[R_ENV_SHAPE][3:0];

endmodule

// File: tb/tb_ay_bus_register_file.sv
// Self-checking bench for ay_bus_register_file (CHIP_ADDR=0, SYNC_STAGES=2).
module tb_ay_bus_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        bdir, bc1;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [11:0] tone_a, tone_b, tone_c;
    logic [4:0]  noise;
    logic [5:0]  mixer;
    logic [4:0]  amp_a, amp_b, amp_c;
    logic [15:0] env_period;
    logic [3:0]  env_shape;
    logic        env_restart;

    int checks   = 0;
    int failures = 0;

    // Reference model of the register file
    logic [7:0] m_reg [16];
    logic [3:0] m_addr;
    logic       m_sel;
    logic [7:0] bmask [16] = '{8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'h1F, 8'h3F,
                               8'h1F, 8'h1F, 8'h1F, 8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF};

    // Scoreboard queues: expected read bytes, expected env_shape at each restart pulse
    logic [7:0] read_q [$];
    logic [3:0] restart_q [$];

    always #5 clk = ~clk;

    ay_bus_register_file #(
        .CHIP_ADDR   (4'h0),
        .SYNC_STAGES (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_bdir          (bdir),
        .i_bc1           (bc1),
        .i_data_in       (data_in),
        .o_data_out      (data_out),
        .o_data_oe       (data_oe),
        .o_tone_period_a (tone_a),
        .o_tone_period_b (tone_b),
        .o_tone_period_c (tone_c),
        .o_noise_period  (noise),
        .o_mixer         (mixer),
        .o_amp_a         (amp_a),
        .o_amp_b         (amp_b),
        .o_amp_c         (amp_c),
        .o_env_period    (env_period),
        .o_env_shape     (env_shape),
        .o_env_restart   (env_restart)
    );

    function automatic logic [81:0] exp_fields();
        return {m_reg[1][3:0], m_reg[0], m_reg[3][3:0], m_reg[2], m_reg[5][3:0], m_reg[4],
                m_reg[6][4:0], m_reg[7][5:0], m_reg[8][4:0], m_reg[9][4:0], m_reg[10][4:0],
                m_reg[12], m_reg[11], m_reg[13][3:0]};
    endfunction

    function automatic logic [81:0] dut_fields();
        return {tone_a, tone_b, tone_c, noise, mixer, amp_a, amp_b, amp_c, env_period, env_shape};
    endfunction

    task automatic check(input string name, input logic [81:0] act, input logic [81:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hold a bus mode for n clock edges; inputs change 1 time unit after an edge
    task automatic bus(input logic [1:0] mode, input logic [7:0] d, input int n);
        {bdir, bc1} = mode;
        data_in     = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic latch(input logic [7:0] a);
        bus(2'b11, a, 3);
        bus(2'b00, 8'h00, 4);
        m_addr = a[3:0];
        m_sel  = (a[7:4] == 4'h0);
    endtask

    task automatic model_write(input logic [7:0] d);
        if (m_sel) begin
            m_reg[m_addr] = d & bmask[m_addr];
            if (m_addr == 4'd13) restart_q.push_back(d[3:0]);
        end
    endtask

    task automatic write(input logic [7:0] d);
        model_write(d);
        bus(2'b10, d, 3);
        bus(2'b00, 8'h00, 4);
    endtask

    task automatic read();
        if (m_sel) read_q.push_back(m_reg[m_addr] & bmask[m_addr]);
        bus(2'b01, 8'h00, 5);
        bus(2'b00, 8'h00, 4);
    endtask

    // Monitor: compares read data when data_oe rises and env_shape on each restart pulse
    initial begin
        logic prev_oe = 1'b0;
        logic prev_rs = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (data_oe && !prev_oe) begin
                    if (read_q.size() == 0) begin
                        check("unexpected_read", {74'd0, data_out}, 82'h1FF);
                    end else begin
                        check("read_data", {74'd0, data_out}, {74'd0, read_q.pop_front()});
                    end
                end
                if (env_restart) begin
                    check("restart_width", {81'd0, prev_rs}, 82'd0);
                    if (restart_q.size() == 0) begin
                        check("unexpected_restart", 82'd1, 82'd0);
                    end else begin
                        check("restart_shape", {78'd0, env_shape}, {78'd0, restart_q.pop_front()});
                    end
                end
            end
            prev_oe = data_oe;
            prev_rs = env_restart;
        end
    end

    initial begin
        logic oe_seen;
        for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
        m_addr = 4'h0;
        m_sel  = 1'b0;
        reset = 1'b1;
        {bdir, bc1} = 2'b00;
        data_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state over 10 cycles
        for (int i = 0; i < 10; i++) begin
            check("reset_fields", dut_fields(), 82'd0);
            check("reset_oe_restart", {80'd0, data_oe, env_restart}, 82'd0);
            @(posedge clk);
            #1;
        end

        // Latch 0x00, write 0xAB with latency check from raw bdir fall
        latch(8'h00);
        bus(2'b10, 8'hAB, 3);
        {bdir, bc1} = 2'b00;
        data_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("tone_a_early", {70'd0, tone_a}, 82'h000);
        @(posedge clk);
        #1;
        check("tone_a_latency", {70'd0, tone_a}, 82'h0AB);
        model_write(8'hAB);
        bus(2'b00, 8'h00, 3);

        // R1 is 4 bits wide
        latch(8'h01);
        write(8'hFF);
        check("tone_a_hi", {70'd0, tone_a}, 82'hFAB);
        read();
        check("fields_r1", dut_fields(), exp_fields());

        // Mixer drops IO direction bits
        latch(8'h07);
        write(8'hFF);
        check("mixer", {76'd0, mixer}, 82'h3F);
        read();

        // Repeated envelope shape writes, each one restarts
        latch(8'h0D);
        write(8'h0E);
        write(8'h0E);
        check("env_shape", {78'd0, env_shape}, 82'hE);
        check("restart_q_drained", 82'(restart_q.size()), 82'd0);

        // R14 stored and readable
        latch(8'h0E);
        write(8'h5A);
        read();

        // Foreign chip address: write and read ignored
        latch(8'h12);
        write(8'h55);
        check("unselected_fields", dut_fields(), exp_fields());
        {bdir, bc1} = 2'b01;
        oe_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            oe_seen = oe_seen | data_oe;
        end
        bus(2'b00, 8'h00, 4);
        check("unselected_oe", {81'd0, oe_seen}, 82'd0);

        // Reset in the middle of a write to R8
        latch(8'h08);
        bus(2'b10, 8'h1F, 3);
        reset = 1'b1;
        bus(2'b10, 8'h1F, 2);
        bus(2'b00, 8'h00, 2);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
        m_addr = 4'h0;
        m_sel  = 1'b0;
        bus(2'b00, 8'h00, 5);
        check("amp_a_after_reset", {77'd0, amp_a}, 82'd0);
        check("state_idle", {80'd0, dut.r_state}, 82'd0);
        check("fields_after_reset", dut_fields(), exp_fields());

        // Latch straight into write with no inactive gap
        bus(2'b11, 8'h08, 3);
        m_addr = 4'd8;
        m_sel  = 1'b1;
        model_write(8'h10);
        bus(2'b10, 8'h10, 3);
        bus(2'b00, 8'h00, 5);
        check("amp_a_direct", {77'd0, amp_a}, 82'h10);
        read();
        check("fields_final", dut_fields(), exp_fields());

        bus(2'b00, 8'h00, 5);
        check("read_q_empty", 82'(read_q.size()), 82'd0);
        check("restart_q_empty", 82'(restart_q.size()), 82'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
